// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the data-memory SRAM controller.
// Board-level widths and the data-memory base live here.
package sram_controller_pkg;

  localparam int WORD_WIDTH      = 32;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int SRAM_ADDR_WIDTH = 18;
  localparam int DATA_MEM_BASE   = 1024;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC_LO = 3'd1,
    S_ACC_HI = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic                  wr;
    logic [WORD_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } req_t;

  function automatic logic [WORD_WIDTH-1:0] word_offset(
    input logic [WORD_WIDTH-1:0] addr,
    input int                    base
  );
    return (addr - WORD_WIDTH'(base)) >> 2;
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request bus plus SRAM pin bundle.
// master = pipeline/board side, slave = controller.
interface sram_controller_if
  import sram_controller_pkg::*;
#(
  parameter int SRAM_AW = SRAM_ADDR_WIDTH
);

  logic                       rd_en;
  logic                       wr_en;
  logic [WORD_WIDTH-1:0]      address;
  logic [WORD_WIDTH-1:0]      write_data;
  logic [WORD_WIDTH-1:0]      read_data;
  logic                       ready;

  logic [SRAM_AW-1:0]         sram_addr;
  logic [SRAM_DATA_WIDTH-1:0] sram_dq_out;
  logic                       sram_dq_oe;
  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in;
  logic                       sram_we_n;
  logic                       sram_ce_n;
  logic                       sram_oe_n;
  logic                       sram_ub_n;
  logic                       sram_lb_n;

  modport master (
    output rd_en, wr_en, address, write_data,
    output sram_dq_in,
    input  read_data, ready,
    input  sram_addr, sram_dq_out, sram_dq_oe,
    input  sram_we_n, sram_ce_n, sram_oe_n,
    input  sram_ub_n, sram_lb_n
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    input  sram_dq_in,
    output read_data, ready,
    output sram_addr, sram_dq_out, sram_dq_oe,
    output sram_we_n, sram_ce_n, sram_oe_n,
    output sram_ub_n, sram_lb_n
  );

endinterface

// File: rtl/sram_controller.sv
// Splits a 32-bit MEM-stage access into two 16-bit SRAM phases
// and holds ready low until LATENCY cycles after acceptance.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int BASE_ADDR = DATA_MEM_BASE,
  parameter int LATENCY   = 6,
  parameter int SRAM_AW   = SRAM_ADDR_WIDTH
) (
  input logic                clk,
  input logic                rst,
  sram_controller_if.slave   bus
);

  localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 2);

  state_t                     state_q, state_d;
  req_t                       req_q, req_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]      rdata_q, rdata_d;

  logic                       req_vld;
  logic [WORD_WIDTH-1:0]      woff;
  logic [SRAM_AW-2:0]         word;

  logic                       ready;
  logic [SRAM_AW-1:0]         sram_addr;
  logic [SRAM_DATA_WIDTH-1:0] sram_dq_out;
  logic                       sram_dq_oe;
  logic                       sram_we_n;

  logic                       unused_ok;

  assign req_vld   = bus.rd_en | bus.wr_en;
  assign woff      = word_offset(req_q.addr, BASE_ADDR);
  assign word      = woff[SRAM_AW-2:0];
  assign unused_ok = ^woff[WORD_WIDTH-1:SRAM_AW-1];

  // State, counter, captured request and load result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state: accept in IDLE, two half-word phases, pad to LATENCY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          req_d.wr   = bus.wr_en;
          req_d.addr = bus.address;
          req_d.data = bus.write_data;
          cnt_d      = '0;
          state_d    = S_ACC_LO;
        end
      end
      S_ACC_LO: begin
        cnt_d = cnt_q + 4'd1;
        if (!req_q.wr) begin
          rdata_d[15:0] = bus.sram_dq_in;
        end
        state_d = S_ACC_HI;
      end
      S_ACC_HI: begin
        cnt_d = cnt_q + 4'd1;
        if (!req_q.wr) begin
          rdata_d[31:16] = bus.sram_dq_in;
        end
        state_d = (LATENCY <= 3) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin and ready decode from state and captured request
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        ready = ~req_vld;
      end
      (state_q == S_ACC_LO): begin
        sram_addr = {word, 1'b0};
        if (req_q.wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = req_q.data[15:0];
        end
      end
      (state_q == S_ACC_HI): begin
        sram_addr = {word, 1'b1};
        if (req_q.wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = req_q.data[31:16];
        end
      end
      (state_q == S_DONE): begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign bus.ready       = ready;
  assign bus.read_data   = rdata_q;
  assign bus.sram_addr   = sram_addr;
  assign bus.sram_dq_out = sram_dq_out;
  assign bus.sram_dq_oe  = sram_dq_oe;
  assign bus.sram_we_n   = sram_we_n;
  assign bus.sram_ce_n   = 1'b0;
  assign bus.sram_oe_n   = 1'b0;
  assign bus.sram_ub_n   = 1'b0;
  assign bus.sram_lb_n   = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: LATENCY=6 and LATENCY=3 instances,
// each with its own half-word SRAM array.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  bit          sel;
  logic        rd, wr;
  logic [31:0] addr, wd;
  int          cyc = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_controller_if #(.SRAM_AW(18)) bus6 ();
  sram_controller_if #(.SRAM_AW(18)) bus3 ();

  sram_controller #(.BASE_ADDR(1024), .LATENCY(6), .SRAM_AW(18)) u6 (
    .clk(clk), .rst(rst), .bus(bus6.slave));
  sram_controller #(.BASE_ADDR(1024), .LATENCY(3), .SRAM_AW(18)) u3 (
    .clk(clk), .rst(rst), .bus(bus3.slave));

  logic [15:0] mem6 [4096] = '{default: '0};
  logic [15:0] mem3 [4096] = '{default: '0};

  assign bus6.rd_en      = rd & ~sel;
  assign bus6.wr_en      = wr & ~sel;
  assign bus6.address    = addr;
  assign bus6.write_data = wd;
  assign bus6.sram_dq_in = mem6[bus6.sram_addr[11:0]];
  assign bus3.rd_en      = rd & sel;
  assign bus3.wr_en      = wr & sel;
  assign bus3.address    = addr;
  assign bus3.write_data = wd;
  assign bus3.sram_dq_in = mem3[bus3.sram_addr[11:0]];

  always @(posedge clk) begin
    if (!bus6.sram_we_n && bus6.sram_dq_oe)
      mem6[bus6.sram_addr[11:0]] <= bus6.sram_dq_out;
    if (!bus3.sram_we_n && bus3.sram_dq_oe)
      mem3[bus3.sram_addr[11:0]] <= bus3.sram_dq_out;
  end

  wire        m_ready = sel ? bus3.ready : bus6.ready;
  wire [31:0] m_rdata = sel ? bus3.read_data : bus6.read_data;
  wire [17:0] m_addr  = sel ? bus3.sram_addr : bus6.sram_addr;
  wire [15:0] m_dq    = sel ? bus3.sram_dq_out : bus6.sram_dq_out;
  wire        m_oe    = sel ? bus3.sram_dq_oe : bus6.sram_dq_oe;
  wire        m_we    = sel ? bus3.sram_we_n : bus6.sram_we_n;

  logic        tr_rdy  [16];
  logic [17:0] tr_addr [16];
  logic [15:0] tr_dq   [16];
  logic        tr_we   [16];
  logic        tr_oe   [16];
  int          t_acc, t_rdy;

  // word-level reference: memory of 32-bit words and last load value
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd  [2];

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic void ref_op(bit r, bit w, logic [31:0] a,
                                 logic [31:0] d);
    int k;
    k = int'(((a - 32'd1024) >> 2) & 32'h1FFFF) + (sel ? 1000000 : 0);
    if (w) ref_mem[k] = d;
    else if (r) ref_rd[sel] = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the ready cycle
  task automatic do_op(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, output int lat,
                       output logic [31:0] rdv);
    rd = r; wr = w; addr = a; wd = d;
    lat = -1;
    rdv = 32'hx;
    t_acc = cyc;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c < 16) begin
        tr_rdy[c] = m_ready; tr_addr[c] = m_addr; tr_dq[c] = m_dq;
        tr_we[c] = m_we; tr_oe[c] = m_oe;
      end
      if (m_ready) begin
        lat = c; rdv = m_rdata; t_rdy = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rd = 0; wr = 0;
  endtask

  task automatic op_chk(string n, bit r, bit w, logic [31:0] a,
                        logic [31:0] d);
    int lat;
    logic [31:0] rdv;
    ref_op(r, w, a, d);
    do_op(r, w, a, d, lat, rdv);
    check({n, "_lat"}, 32'(lat), sel ? 32'd3 : 32'd6);
    check({n, "_rd"}, rdv, ref_rd[sel]);
  endtask

  typedef struct {
    bit          r, w;
    logic [31:0] a, d;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t        vt [8];
    int          lat;
    logic [31:0] rdv;
    int          acc0;

    vt[0] = '{0, 1, 32'd1040, 32'h0BADF00D, 32'h11112222};
    vt[1] = '{1, 0, 32'd1040, 32'h0, 32'h0BADF00D};
    vt[2] = '{1, 0, 32'd1028, 32'h0, 32'hDEADBEEF};
    vt[3] = '{0, 1, 32'd1028, 32'hFFFF0000, 32'hDEADBEEF};
    vt[4] = '{1, 0, 32'd1028, 32'h0, 32'hFFFF0000};
    vt[5] = '{1, 0, 32'd1036, 32'h0, 32'h0};
    vt[6] = '{0, 1, 32'd1032 + 32'h80000, 32'h77778888, 32'h0};
    vt[7] = '{1, 0, 32'd1032, 32'h0, 32'h77778888};

    ref_rd[0] = 0; ref_rd[1] = 0;
    rst = 1; sel = 0; rd = 0; wr = 0; addr = 0; wd = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready", {31'b0, m_ready}, 32'd1);
    check("rst_rdata", m_rdata, 32'h0);
    check("rst_we_n", {31'b0, m_we}, 32'd1);
    check("rst_oe", {31'b0, m_oe}, 32'd0);
    check("rst_addr", {14'b0, m_addr}, 32'd0);
    check("rst_dq", {16'b0, m_dq}, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'b0, m_ready}, 32'd1);
      check("idle_we_n", {31'b0, m_we}, 32'd1);
      check("idle_oe", {31'b0, m_oe}, 32'd0);
    end
    @(posedge clk); #1;

    ref_op(0, 1, 32'd1028, 32'hDEADBEEF);
    do_op(0, 1, 32'd1028, 32'hDEADBEEF, lat, rdv);
    check("st_lat", 32'(lat), 32'd6);
    check("st_addr1", {14'b0, tr_addr[1]}, 32'd2);
    check("st_dq1", {16'b0, tr_dq[1]}, 32'hBEEF);
    check("st_we1", {31'b0, tr_we[1]}, 32'd0);
    check("st_oe1", {31'b0, tr_oe[1]}, 32'd1);
    check("st_addr2", {14'b0, tr_addr[2]}, 32'd3);
    check("st_dq2", {16'b0, tr_dq[2]}, 32'hDEAD);
    check("st_we2", {31'b0, tr_we[2]}, 32'd0);
    check("st_we3", {31'b0, tr_we[3]}, 32'd1);
    for (int c = 0; c < 6; c++)
      check("st_busy", {31'b0, tr_rdy[c]}, 32'd0);

    ref_op(1, 0, 32'd1028, 32'h0);
    do_op(1, 0, 32'd1028, 32'h0, lat, rdv);
    check("ld_lat", 32'(lat), 32'd6);
    check("ld_rd", rdv, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld_hold", m_rdata, 32'hDEADBEEF);
      check("ld_hold_rdy", {31'b0, m_ready}, 32'd1);
      @(posedge clk); #1;
    end

    ref_op(0, 1, 32'd1024, 32'h11112222);
    do_op(0, 1, 32'd1024, 32'h11112222, lat, rdv);
    acc0 = t_acc;
    check("b2b_st_lat", 32'(lat), 32'd6);
    ref_op(1, 0, 32'd1024, 32'h0);
    do_op(1, 0, 32'd1024, 32'h0, lat, rdv);
    check("b2b_cycle", 32'(t_rdy - acc0), 32'd13);
    check("b2b_rd", rdv, 32'h11112222);

    foreach (vt[i]) begin
      ref_op(vt[i].r, vt[i].w, vt[i].a, vt[i].d);
      do_op(vt[i].r, vt[i].w, vt[i].a, vt[i].d, lat, rdv);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd6);
      check($sformatf("vec%0d_rd", i), rdv, vt[i].exp_rd);
    end

    for (int i = 0; i < 24; i++) begin
      bit          r;
      logic [31:0] a, d;
      r = $urandom_range(0, 1) == 1;
      a = 32'd1024 + 32'(4 * $urandom_range(0, 255));
      d = $urandom;
      op_chk($sformatf("rnd%0d", i), r, ~r, a, d);
    end

    ref_op(0, 1, 32'd1044, 32'h13572468);
    rd = 0; wr = 1; addr = 32'd1044; wd = 32'h13572468;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; wr = 0;
    ref_rd[0] = 0; ref_rd[1] = 0;
    @(negedge clk);
    check("mrst_ready", {31'b0, m_ready}, 32'd1);
    check("mrst_we_n", {31'b0, m_we}, 32'd1);
    check("mrst_oe", {31'b0, m_oe}, 32'd0);
    check("mrst_rdata", m_rdata, 32'h0);
    check("mrst_addr", {14'b0, m_addr}, 32'd0);
    @(posedge clk); #1;
    rd = 1; addr = 32'd1044;
    #1;
    check("mrst_req_rdy", {31'b0, m_ready}, 32'd0);
    op_chk("mrst_ld", 1, 0, 32'd1044, 32'h0);
    check("mrst_ld_val", ref_rd[0], 32'h13572468);

    sel = 1;
    op_chk("l3_st", 0, 1, 32'd1032, 32'hCAFEF00D);
    check("l3_st_addr2", {14'b0, tr_addr[2]}, 32'd5);
    check("l3_st_dq2", {16'b0, tr_dq[2]}, 32'hCAFE);
    op_chk("l3_ld", 1, 0, 32'd1032, 32'h0);
    check("l3_ld_val", ref_rd[1], 32'hCAFEF00D);
    op_chk("l3_both", 1, 1, 32'd1032, 32'h12345678);
    check("l3_both_rd", m_rdata, 32'hCAFEF00D);
    op_chk("l3_ld2", 1, 0, 32'd1032, 32'h0);
    check("l3_ld2_val", m_rdata, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the MEM-stage's 32-bit data-memory accesses onto the 16-bit external SRAM, one half-word per access phase.
- Produces a `ready` signal; the pipeline freeze is `~ready` and stalls IF/ID/EXE/MEM while an access is in flight.
- Sits between the EXE/MEM pipeline register (ALU result as address, forwarded Rm value as store data) and the board SRAM pins.

Parameters:
- BASE_ADDR, 1024, byte address mapped to SRAM word 0; subtracted before mapping.
- LATENCY, 6, cycles from request acceptance to `ready`; legal range 3..15.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  system clock; everything on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  load request from MEM stage; held until `ready`.
- wr_en  in  1  store request from MEM stage; held until `ready`.
- address  in  32  byte address; word aligned.
- write_data  in  32  store data.
- read_data  out  32  load result.
- ready  out  1  access complete / no access pending.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to pad.
- sram_dq_oe  out  1  pad output enable.
- sram_dq_in  in  16  read data from pad.
- sram_we_n  out  1  active-low write strobe.
- sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  tied 0.

Behaviour:
- States: IDLE, ACC_LO, ACC_HI, WAIT, DONE (localparam encoding).
- IDLE:
  - If `rd_en|wr_en`: capture address, write_data and op; clear counter; go to ACC_LO.
  - `ready = ~(rd_en|wr_en)`, combinational in IDLE.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2.
  - ACC_LO drives sram_addr = {word[SRAM_AW-2:0], 0}; ACC_HI drives {word[SRAM_AW-2:0], 1}.
  - Higher bits are truncated; no range check.
- Write op:
  - ACC_LO: sram_we_n = 0, sram_dq_oe = 1, sram_dq_out = data[15:0].
  - ACC_HI: same strobes, sram_dq_out = data[31:16].
  - All other states: sram_we_n = 1, sram_dq_oe = 0.
- Read op:
  - sram_dq_in is registered into read_data[15:0] at the end of ACC_LO and into read_data[31:16] at the end of ACC_HI.
  - read_data holds until the next read completes its phases; writes never modify it.
- WAIT: counts until the DONE cycle is exactly LATENCY cycles after the accept cycle.
  - Example with LATENCY = 6: accept at cycle 0, LO at 1, HI at 2, WAIT at 3..5, DONE at 6.
  - LATENCY = 3 means WAIT is skipped.
- DONE:
  - `ready = 1` for exactly one cycle; next state is IDLE unconditionally.
  - The pipeline advances on this edge, so the request seen in the following IDLE is the next instruction's.
  - Back-to-back memory ops therefore each cost LATENCY+1 cycles.
- `ready = 0` in ACC_LO, ACC_HI and WAIT, regardless of the request inputs.
- Request inputs are ignored outside IDLE; captured values govern the access.
- Simultaneous `rd_en & wr_en` is illegal from the decoder; treated as a write, read_data unchanged.
- Reset (including mid-access) forces:
  - state IDLE, counter 0, read_data 0, captured regs 0;
  - sram_we_n 1, sram_dq_oe 0, sram_addr 0, sram_dq_out 0.
  - A partially written word may remain in SRAM; no retry.
- SRAM pin outputs are decoded combinationally from the state and captured registers.

Decomposition:
- defines.v gains `SRAM_DATA_WIDTH 16, `SRAM_ADDR_WIDTH 18 and `DATA_MEM_BASE 1024; `WORD_WIDTH is reused.
- State encoding stays as local constants.
- No sub-module; the counter is 4 bits, inline.
- The top level builds the inout pad: SRAM_DQ = sram_dq_oe ? sram_dq_out : 16'bz.

Test Plan:
- Idle: rd_en = wr_en = 0 for 10 cycles -> ready = 1 every cycle; sram_we_n = 1; sram_dq_oe = 0.
- Store: wr_en, address = 1028, write_data = 0xDEADBEEF.
  - Cycle 1: sram_addr = 2, dq = 0xBEEF, we_n = 0.
  - Cycle 2: sram_addr = 3, dq = 0xDEAD, we_n = 0.
  - ready = 0 for cycles 0-5, ready = 1 at cycle 6.
- Load: rd_en, address = 1028, behavioural SRAM model preloaded from the previous store -> read_data = 0xDEADBEEF at cycle 6; value holds after rd_en drops.
- Back-to-back: store 0x11112222 to 1024, then load from 1024 -> second access accepted in the cycle after DONE; read_data = 0x11112222 at cycle 13.
- Reset mid-access: assert rst during WAIT of a store -> next cycle state IDLE, ready follows the request, we_n = 1, read_data = 0; a new load then completes normally in LATENCY cycles.
- LATENCY = 3 build: load -> ready at cycle 3, no WAIT cycles; rd_en & wr_en together behaves as a write with read_data unchanged.
